// File: rtl/pulse_seq_pkg.sv
// -----------------------------------------------------------------------------
// pulse_seq_pkg
//   Shared types and helpers for the pulse_sequencer slice.
//   - CFG_W / REP_W : widths of the delay/width/gap and repeat configuration.
//   - seq_state_t   : sequencer FSM states, explicitly encoded so the values
//                     stay stable for anything that decodes them in debug.
//   - clamp_cfg / clamp_rep : force a zero configuration value up to 1.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

package pulse_seq_pkg;

  localparam int CFG_W = 32;
  localparam int REP_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } seq_state_t;

  // The generator counts a zero delay/width through the full 2^32 range,
  // so zero is promoted to the shortest legal value.
  function automatic logic [CFG_W-1:0] clamp_cfg(input logic [CFG_W-1:0] value);
    return (value == '0) ? CFG_W'(1) : value;
  endfunction

  // A zero repeat count still produces one pulse.
  function automatic logic [REP_W-1:0] clamp_rep(input logic [REP_W-1:0] value);
    return (value == '0) ? REP_W'(1) : value;
  endfunction

endpackage : pulse_seq_pkg

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Conditions a raw, active-low, asynchronous push-button into a single-cycle
//   press strobe.
//   Ports:
//     clk      in  : system clock
//     reset_n  in  : asynchronous active-low reset
//     key_n    in  : raw push-button level (low = pressed), asynchronous
//     press    out : one-cycle strobe on an accepted 1->0 debounced transition
//   Parameter:
//     DEBOUNCE_CYCLES : consecutive stable synchronized cycles needed before
//                       the debounced level follows the key.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             press_q, press_d;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;

    // Count consecutive cycles in which the synchronized key disagrees with
    // the accepted level; a single agreeing cycle (bounce) restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;  // only the 1->0 (press) edge produces an event
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule : key_debouncer

// File: rtl/pulse_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_sequencer
//   Upstream control stage for pulse_generator. A debounced key press starts a
//   burst of generator starts; each start uses a delay/width latched (and
//   clamped to >= 1) at accept time, and consecutive starts are separated by
//   a programmable idle gap after the generator drops busy.
//   Ports:
//     clk, reset_n    : clock, asynchronous active-low reset
//     key_n           : raw push-button, active-low, asynchronous
//     abort           : synchronous active-high burst abort
//     cfg_delay/width : per-pulse delay and width (cycles)
//     cfg_gap         : idle cycles between busy falling and the next start
//     cfg_repeat      : pulses per burst
//     gen_busy        : generator busy (delay_led | pulse_led)
//     gen_start       : one-cycle start strobe to the generator
//     gen_delay/width : latched values driven to the generator
//     busy            : sequencer not IDLE
//     done            : one-cycle strobe at burst completion
//     err             : sticky acknowledge-timeout flag, cleared on accept
//   Parameters:
//     DEBOUNCE_CYCLES : key debounce length
//     ACK_TIMEOUT     : cycles allowed in WAIT_ACK before flagging err
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_n,
  input  logic             abort,
  input  logic [CFG_W-1:0] cfg_delay,
  input  logic [CFG_W-1:0] cfg_width,
  input  logic [CFG_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic             gen_busy,
  output logic             gen_start,
  output logic [CFG_W-1:0] gen_delay,
  output logic [CFG_W-1:0] gen_width,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------------
  logic press;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_n),
    .press   (press)
  );

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  seq_state_t       state_q,     state_d;
  logic             gen_start_q, gen_start_d;
  logic [CFG_W-1:0] gen_delay_q, gen_delay_d;
  logic [CFG_W-1:0] gen_width_q, gen_width_d;
  logic [CFG_W-1:0] gap_q,       gap_d;
  logic [CFG_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic [REP_W-1:0] rem_q,       rem_d;
  logic [ACK_W-1:0] ack_cnt_q,   ack_cnt_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             err_q,       err_d;

  // The state register already reads IDLE in the cycle done is strobed, but
  // the burst is still considered to be finishing then; a press landing on
  // that cycle is dropped rather than starting a new burst back-to-back.
  logic accept;
  assign accept = press && (state_q == IDLE) && !done_q;

  always_comb begin
    state_d     = state_q;
    gen_delay_d = gen_delay_q;
    gen_width_d = gen_width_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    rem_d       = rem_q;
    ack_cnt_d   = ack_cnt_q;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          gen_delay_d = clamp_cfg(cfg_delay);
          gen_width_d = clamp_cfg(cfg_width);
          gap_d       = cfg_gap;
          rem_d       = clamp_rep(cfg_repeat);
          err_d       = 1'b0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        ack_cnt_d = '0;
        state_d   = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (gen_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          // Generator never acknowledged: abandon the burst without done.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!gen_busy) begin
          rem_d = rem_q - REP_W'(1);
          if (rem_q == REP_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (gap_q == '0) begin
            state_d = ISSUE;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = GAP;
          end
        end
      end

      GAP: begin
        // Leaving at count 1 puts the next start exactly gap cycles after
        // the GAP entry cycle.
        if (gap_cnt_q == CFG_W'(1)) begin
          state_d = ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q - CFG_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort outranks every in-state decision, including a coincident ack
    // timeout or burst completion: no done, and err keeps its prior value.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = err_q;
    end

    // Registered outputs are derived from the next state so they line up
    // with the state register cycle for cycle.
    gen_start_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gen_start_q <= 1'b0;
      gen_delay_q <= CFG_W'(1);
      gen_width_q <= CFG_W'(1);
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      rem_q       <= '0;
      ack_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gen_start_q <= gen_start_d;
      gen_delay_q <= gen_delay_d;
      gen_width_q <= gen_width_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      rem_q       <= rem_d;
      ack_cnt_q   <= ack_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign gen_start = gen_start_q;
  assign gen_delay = gen_delay_q;
  assign gen_width = gen_width_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule : pulse_sequencer

// File: tb/tb_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pulse_sequencer
//   Directed bench for pulse_sequencer with DEBOUNCE_CYCLES=4, ACK_TIMEOUT=4.
//   A small generator model holds gen_busy high for delay+width cycles starting
//   the cycle after gen_start. Monitors log event cycles; expected cycles are
//   hand-derived from the press cycle c:
//     press strobe at c+6, gen_start at c+7, generator busy c+8 .. c+7+D+W,
//     busy first low at T = c+8+D+W, next start at T+1+gap, done at T+1.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_n = 1'b1;
  logic        abort = 1'b0;
  logic [31:0] cfg_delay = 32'd0;
  logic [31:0] cfg_width = 32'd0;
  logic [31:0] cfg_gap = 32'd0;
  logic [15:0] cfg_repeat = 16'd0;
  logic        gen_busy;
  logic        gen_start;
  logic [31:0] gen_delay;
  logic [31:0] gen_width;
  logic        busy;
  logic        done;
  logic        err;

  pulse_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .ACK_TIMEOUT     (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (key_n),
    .abort      (abort),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_repeat (cfg_repeat),
    .gen_busy   (gen_busy),
    .gen_start  (gen_start),
    .gen_delay  (gen_delay),
    .gen_width  (gen_width),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Generator model; model_en=0 emulates a generator that never goes busy.
  logic        model_en = 1'b1;
  logic [32:0] bcnt = '0;
  always @(posedge clk) begin
    if (gen_start && model_en) bcnt <= {1'b0, gen_delay} + {1'b0, gen_width};
    else if (bcnt != '0)       bcnt <= bcnt - 33'd1;
  end
  assign gen_busy = (bcnt != '0);

  // Event monitors, sampled on the falling edge.
  int   starts[$];
  int   falls[$];
  int   dones[$];
  int   done_busy[$];
  int   err_rises[$];
  logic prev_busy = 1'b0;
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    if (gen_start) starts.push_back(cyc);
    if (prev_busy && !gen_busy) falls.push_back(cyc);
    if (done) begin
      dones.push_back(cyc);
      done_busy.push_back(int'(busy));
    end
    if (err && !prev_err) err_rises.push_back(cyc);
    prev_busy = gen_busy;
    prev_err  = err;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(output int pc);
    @(negedge clk);
    key_n = 1'b0;
    pc = cyc;
  endtask

  task automatic release_key();
    @(negedge clk);
    key_n = 1'b1;
    tick(10);
  endtask

  task automatic set_cfg(input int d, input int w, input int g, input int r);
    cfg_delay  = d;
    cfg_width  = w;
    cfg_gap    = g;
    cfg_repeat = 16'(r);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int pc;
  int s0, d0, e0, f0;

  initial begin
    // ---------------- reset values ----------------
    tick(3);
    check("rst_gen_start", int'(gen_start), 0);
    check("rst_busy",      int'(busy),      0);
    check("rst_done",      int'(done),      0);
    check("rst_err",       int'(err),       0);
    check("rst_gen_delay", int'(gen_delay), 1);
    check("rst_gen_width", int'(gen_width), 1);
    @(negedge clk);
    reset_n = 1'b1;
    tick(3);

    // ---------------- 1: single pulse ----------------
    set_cfg(3, 2, 0, 1);
    s0 = starts.size(); d0 = dones.size(); f0 = falls.size();
    press_key(pc);
    tick(25);
    check("t1_starts",     starts.size() - s0, 1);
    check("t1_start_cyc",  at(starts, s0), pc + 7);
    check("t1_gen_delay",  int'(gen_delay), 3);
    check("t1_gen_width",  int'(gen_width), 2);
    check("t1_dones",      dones.size() - d0, 1);
    check("t1_done_cyc",   at(dones, d0), pc + 14);
    check("t1_done_after_fall", at(dones, d0) - at(falls, f0), 1);
    check("t1_busy_at_done", at(done_busy, d0), 0);
    check("t1_busy_after", int'(busy), 0);
    s0 = starts.size();
    release_key();
    check("t1_release_no_start", starts.size() - s0, 0);

    // ---------------- 2: burst with gap, config changed mid-burst ----------------
    set_cfg(3, 2, 5, 3);
    s0 = starts.size(); d0 = dones.size(); f0 = falls.size();
    press_key(pc);
    tick(10);
    set_cfg(9, 9, 0, 1);
    tick(40);
    check("t2_starts",    starts.size() - s0, 3);
    check("t2_start1",    at(starts, s0 + 1), pc + 19);
    check("t2_start2",    at(starts, s0 + 2), pc + 31);
    check("t2_spacing1",  at(starts, s0 + 1) - at(falls, f0), 6);
    check("t2_spacing2",  at(starts, s0 + 2) - at(falls, f0 + 1), 6);
    check("t2_dones",     dones.size() - d0, 1);
    check("t2_done_cyc",  at(dones, d0), pc + 38);
    check("t2_delay_held", int'(gen_delay), 3);
    check("t2_width_held", int'(gen_width), 2);
    release_key();

    // ---------------- 3: bounce on press and release ----------------
    set_cfg(2, 2, 0, 1);
    s0 = starts.size(); d0 = dones.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_n = ~key_n;
      tick(1);
    end
    check("t3_no_start_bounce", starts.size() - s0, 0);
    press_key(pc);
    tick(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_n = ~key_n;
      tick(1);
    end
    @(negedge clk);
    key_n = 1'b1;
    tick(20);
    check("t3_starts",    starts.size() - s0, 1);
    check("t3_start_cyc", at(starts, s0), pc + 7);
    check("t3_dones",     dones.size() - d0, 1);

    // ---------------- 4: clamping ----------------
    set_cfg(0, 0, 0, 0);
    s0 = starts.size(); d0 = dones.size();
    press_key(pc);
    tick(20);
    check("t4_gen_delay", int'(gen_delay), 1);
    check("t4_gen_width", int'(gen_width), 1);
    check("t4_done_cyc",  at(dones, d0), pc + 11);
    tick(30);
    check("t4_starts",    starts.size() - s0, 1);
    check("t4_dones",     dones.size() - d0, 1);
    check("t4_busy",      int'(busy), 0);
    release_key();

    // ---------------- 5: no acknowledge, then err cleared ----------------
    model_en = 1'b0;
    set_cfg(3, 2, 0, 1);
    d0 = dones.size(); e0 = err_rises.size(); s0 = starts.size();
    press_key(pc);
    tick(20);
    check("t5_err",       int'(err), 1);
    check("t5_err_cyc",   at(err_rises, e0), pc + 12);
    check("t5_no_done",   dones.size() - d0, 0);
    check("t5_busy",      int'(busy), 0);
    check("t5_starts",    starts.size() - s0, 1);
    release_key();
    model_en = 1'b1;
    d0 = dones.size();
    press_key(pc);
    tick(8);
    check("t5_err_cleared", int'(err), 0);
    tick(15);
    check("t5_done_after_clear", dones.size() - d0, 1);
    release_key();

    // ---------------- 6a: abort during GAP ----------------
    set_cfg(2, 2, 10, 3);
    s0 = starts.size(); d0 = dones.size();
    press_key(pc);
    tick(15);  // cycle pc+15 lies inside GAP (pc+13 .. pc+22)
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t6a_busy_next", int'(busy), 0);
    tick(40);
    check("t6a_starts",   starts.size() - s0, 1);
    check("t6a_no_done",  dones.size() - d0, 0);
    check("t6a_err",      int'(err), 0);
    release_key();

    // ---------------- 6b: reset mid-burst ----------------
    set_cfg(5, 5, 0, 3);
    s0 = starts.size();
    press_key(pc);
    tick(12);
    check("t6b_pre_delay", int'(gen_delay), 5);
    key_n   = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t6b_gen_start", int'(gen_start), 0);
    check("t6b_busy",      int'(busy),      0);
    check("t6b_done",      int'(done),      0);
    check("t6b_err",       int'(err),       0);
    check("t6b_gen_delay", int'(gen_delay), 1);
    check("t6b_gen_width", int'(gen_width), 1);
    tick(3);
    reset_n = 1'b1;
    tick(30);
    check("t6b_starts",   starts.size() - s0, 1);
    check("t6b_idle",     int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pulse_sequencer
